// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: funct3 codes, FSM states, fault causes
// and the legality helpers used at request acceptance.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

  typedef enum logic [1:0] {MISALIGNED, ILLEGAL, TIMEOUT} fault_cause_t;

  // Per-request fields that must survive past acceptance
  typedef struct packed {
    logic       is_store;
    logic [2:0] funct3;
    logic [1:0] offset;
    logic [4:0] rd_addr;
  } req_meta_t;

  function automatic logic f3_illegal(input logic is_store, input logic [2:0] funct3);
    if (is_store) return funct3 > F3_W;
    return (funct3 == 3'd3) || (funct3 >= 3'd6);
  endfunction

  // Only meaningful for legal codes; illegal ones are rejected first
  function automatic logic f3_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3[1:0])
      2'd1:    return offset[0];
      2'd2:    return offset != 2'd0;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Execute-side request, data-memory bus and write-back signals of the LSU.
// master = the LSU itself, slave = execute stage / memory / write-back side.
interface lsu_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            is_store;
  logic [2:0]      funct3;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] store_data;
  logic [4:0]      rd_addr;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_wstrb;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rdata;

  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] mem_data;
  logic            store_done;
  logic            lsu_fault;
  logic [1:0]      fault_cause;

  modport master (
    input  req_valid, is_store, funct3, addr, store_data, rd_addr,
    input  mem_req_ready, mem_rsp_valid, mem_rdata,
    output req_ready,
    output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output wb_valid, wb_rd, mem_data, store_done, lsu_fault, fault_cause
  );

  modport slave (
    output req_valid, is_store, funct3, addr, store_data, rd_addr,
    output mem_req_ready, mem_rsp_valid, mem_rdata,
    input  req_ready,
    input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  wb_valid, wb_rd, mem_data, store_done, lsu_fault, fault_cause
  );

endinterface

// File: rtl/lsu_load_extend.sv
// Load data aligner: picks byte/halfword lane by offset and sign/zero-extends.
// Purely combinational, zero latency, no flow control.
module load_extend
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[8*offset +: 8];
    half_v = offset[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    result = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_BU:   result = {{(XLEN-8){1'b0}}, byte_v};
      F3_H:    result = {{(XLEN-16){half_v[15]}}, half_v};
      F3_HU:   result = {{(XLEN-16){1'b0}}, half_v};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit, single outstanding bus access; load accept->wb_valid 3 cycles, store accept->store_done 2 (zero-wait).
// Backpressure: req_ready only in IDLE; bus request held stable until mem_req_ready; response wait bounded by RSP_TIMEOUT.
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int RSP_TIMEOUT = 255
) (
  input logic   clk,
  input logic   rst_n,
  lsu_if.master bus
);

  localparam int CW = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = (RSP_TIMEOUT > 0) ? CW'(RSP_TIMEOUT - 1) : '0;

  lsu_state_t      state;
  req_meta_t       meta_q;
  logic [CW-1:0]   wait_cnt;
  logic            accept;
  logic            illegal;
  logic            misaligned;
  logic [3:0]      wstrb_d;
  logic [XLEN-1:0] wdata_d;
  logic [XLEN-1:0] ext_data;

  assign accept     = bus.req_valid && bus.req_ready;
  assign illegal    = f3_illegal(bus.is_store, bus.funct3);
  assign misaligned = f3_misaligned(bus.funct3, bus.addr[1:0]);

  always_comb begin
    wstrb_d = 4'b0000;
    wdata_d = bus.store_data;
    if (bus.is_store) begin
      case (bus.funct3[1:0])
        2'd0: begin
          wstrb_d = 4'b0001 << bus.addr[1:0];
          wdata_d = {4{bus.store_data[7:0]}};
        end
        2'd1: begin
          wstrb_d = 4'b0011 << bus.addr[1:0];
          wdata_d = {2{bus.store_data[15:0]}};
        end
        default: begin
          wstrb_d = 4'b1111;
          wdata_d = bus.store_data;
        end
      endcase
    end
  end

  // Extraction runs on the live bus word so data lands in mem_data on the capture edge
  load_extend #(.XLEN(XLEN)) u_load_extend (
    .funct3 (meta_q.funct3),
    .offset (meta_q.offset),
    .rdata  (bus.mem_rdata),
    .result (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      meta_q            <= '0;
      wait_cnt          <= '0;
      bus.req_ready     <= 1'b1;
      bus.mem_req_valid <= 1'b0;
      bus.mem_we        <= 1'b0;
      bus.mem_addr      <= '0;
      bus.mem_wdata     <= '0;
      bus.mem_wstrb     <= '0;
      bus.wb_valid      <= 1'b0;
      bus.wb_rd         <= '0;
      bus.mem_data      <= '0;
      bus.store_done    <= 1'b0;
      bus.lsu_fault     <= 1'b0;
      bus.fault_cause   <= '0;
    end else begin
      bus.wb_valid   <= 1'b0;
      bus.store_done <= 1'b0;
      bus.lsu_fault  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (illegal) begin
              bus.lsu_fault   <= 1'b1;
              bus.fault_cause <= ILLEGAL;
            end else if (misaligned) begin
              bus.lsu_fault   <= 1'b1;
              bus.fault_cause <= MISALIGNED;
            end else begin
              meta_q            <= '{is_store: bus.is_store, funct3: bus.funct3,
                                     offset: bus.addr[1:0], rd_addr: bus.rd_addr};
              bus.mem_req_valid <= 1'b1;
              bus.mem_we        <= bus.is_store;
              bus.mem_addr      <= {bus.addr[XLEN-1:2], 2'b00};
              bus.mem_wdata     <= wdata_d;
              bus.mem_wstrb     <= wstrb_d;
              bus.req_ready     <= 1'b0;
              state             <= REQ;
            end
          end
        end
        REQ: begin
          if (bus.mem_req_ready) begin
            bus.mem_req_valid <= 1'b0;
            if (meta_q.is_store) begin
              bus.store_done <= 1'b1;
              bus.req_ready  <= 1'b1;
              state          <= IDLE;
            end else begin
              wait_cnt <= '0;
              state    <= WAIT;
            end
          end
        end
        WAIT: begin
          // A response in the final allowed cycle beats the timeout
          if (bus.mem_rsp_valid) begin
            bus.wb_valid <= 1'b1;
            bus.wb_rd    <= meta_q.rd_addr;
            bus.mem_data <= ext_data;
            state        <= DONE;
          end else if (RSP_TIMEOUT != 0 && wait_cnt == TO_LAST) begin
            bus.lsu_fault   <= 1'b1;
            bus.fault_cause <= TIMEOUT;
            bus.req_ready   <= 1'b1;
            state           <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end
        default: begin
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Randomized + directed bench for lsu against a byte-lane arithmetic reference model.
module tb_lsu;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  logic [1:0] exp_cause;

  lsu_if #(.XLEN(32)) bus ();

  lsu #(.XLEN(32), .RSP_TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic garbage_req();
    bus.is_store   = 1'($urandom);
    bus.funct3     = 3'($urandom);
    bus.addr       = $urandom;
    bus.store_data = $urandom;
    bus.rd_addr    = 5'($urandom);
  endtask

  // pdly < 0 means the memory never answers
  task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [4:0] rd, input logic [31:0] rdata,
                        input int rdly, input int pdly);
    int          acc;
    int          t;
    int          sz;
    int          sh;
    bit          legal;
    bit          flt;
    logic [31:0] ewd;
    logic [3:0]  ews;
    logic [31:0] eres;
    longint      mask;
    longint      v;

    sz    = 1 << f3[1:0];
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    flt   = !legal || ((a % sz) != 0);
    ews   = st ? 4'(((1 << sz) - 1) << (a % 4)) : 4'b0000;
    for (int i = 0; i < 4; i++) ewd[8*i +: 8] = sd[8*(i % sz) +: 8];
    if (sz == 4) eres = rdata;
    else begin
      sh   = ((a % 4) / sz) * sz * 8;
      mask = (64'd1 << (8 * sz)) - 1;
      v    = (longint'(rdata) >> sh) & mask;
      if (f3 < 3'd4 && v[8*sz-1]) v = v | ~mask;
      eres = v[31:0];
    end

    @(negedge clk);
    t = 0;
    while (!bus.req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.is_store   = st;
    bus.funct3     = f3;
    bus.addr       = a;
    bus.store_data = sd;
    bus.rd_addr    = rd;
    acc            = cyc;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    garbage_req();

    if (flt) begin
      exp_cause = legal ? 2'd0 : 2'd1;
      @(negedge clk);
      check("fault_pulse", 32'(bus.lsu_fault), 32'd1);
      check("fault_cause", 32'(bus.fault_cause), 32'(exp_cause));
      check("fault_no_req", 32'(bus.mem_req_valid), 32'd0);
      check("fault_ready", 32'(bus.req_ready), 32'd1);
      check("fault_lat", 32'(cyc - acc), 32'd1);
      @(negedge clk);
      check("fault_once", 32'(bus.lsu_fault), 32'd0);
      return;
    end

    @(negedge clk);
    check("req_valid", 32'(bus.mem_req_valid), 32'd1);
    check("req_busy", 32'(bus.req_ready), 32'd0);
    check("req_addr", bus.mem_addr, {a[31:2], 2'b00});
    check("req_we", 32'(bus.mem_we), 32'(st));
    check("req_wstrb", 32'(bus.mem_wstrb), 32'(ews));
    if (st) check("req_wdata", bus.mem_wdata, ewd);
    for (int i = 0; i < rdly; i++) begin
      bus.req_valid     = 1'b1;
      bus.mem_rsp_valid = 1'($urandom);
      bus.mem_rdata     = $urandom;
      @(negedge clk);
      check("hold_valid", 32'(bus.mem_req_valid), 32'd1);
      check("hold_addr", bus.mem_addr, {a[31:2], 2'b00});
      check("hold_wstrb", 32'(bus.mem_wstrb), 32'(ews));
      if (st) check("hold_wdata", bus.mem_wdata, ewd);
    end
    bus.req_valid     = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_req_ready = 1'b0;

    if (st) begin
      @(negedge clk);
      check("store_done", 32'(bus.store_done), 32'd1);
      check("store_lat", 32'(cyc - acc), 32'(2 + rdly));
      check("store_req_drop", 32'(bus.mem_req_valid), 32'd0);
      @(negedge clk);
      check("store_done_once", 32'(bus.store_done), 32'd0);
    end else if (pdly < 0) begin
      exp_cause = 2'd2;
      t = 0;
      @(negedge clk);
      while (!bus.lsu_fault && t < 40) begin
        check("to_no_wb", 32'(bus.wb_valid), 32'd0);
        @(negedge clk);
        t++;
      end
      check("to_fault", 32'(bus.lsu_fault), 32'd1);
      check("to_cause", 32'(bus.fault_cause), 32'd2);
      check("to_lat", 32'(cyc - acc), 32'(10 + rdly));
      check("to_ready", 32'(bus.req_ready), 32'd1);
    end else begin
      for (int i = 0; i < pdly; i++) begin
        @(negedge clk);
        check("wait_no_wb", 32'(bus.wb_valid), 32'd0);
      end
      @(negedge clk);
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rdata     = rdata;
      @(posedge clk);
      #1;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rdata     = $urandom;
      @(negedge clk);
      check("wb_valid", 32'(bus.wb_valid), 32'd1);
      check("wb_data", bus.mem_data, eres);
      check("wb_rd", 32'(bus.wb_rd), 32'(rd));
      check("wb_lat", 32'(cyc - acc), 32'(3 + rdly + pdly));
      @(negedge clk);
      check("wb_once", 32'(bus.wb_valid), 32'd0);
      check("wb_data_hold", bus.mem_data, eres);
    end
    check("cause_hold", 32'(bus.fault_cause), 32'(exp_cause));
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    check({pfx, "_mem_req_valid"}, 32'(bus.mem_req_valid), 32'd0);
    check({pfx, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    check({pfx, "_mem_addr"}, bus.mem_addr, 32'd0);
    check({pfx, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    check({pfx, "_mem_wstrb"}, 32'(bus.mem_wstrb), 32'd0);
    check({pfx, "_wb_valid"}, 32'(bus.wb_valid), 32'd0);
    check({pfx, "_wb_rd"}, 32'(bus.wb_rd), 32'd0);
    check({pfx, "_mem_data"}, bus.mem_data, 32'd0);
    check({pfx, "_store_done"}, 32'(bus.store_done), 32'd0);
    check({pfx, "_lsu_fault"}, 32'(bus.lsu_fault), 32'd0);
    check({pfx, "_fault_cause"}, 32'(bus.fault_cause), 32'd0);
  endtask

  initial begin
    bit          st;
    logic [2:0]  f3;
    logic [31:0] a;
    int          pd;

    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    exp_cause = 2'd0;
    rst_n = 1'b0;
    bus.req_valid     = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata     = '0;
    garbage_req();
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // Directed cases
    run_op(1'b0, 3'd0, 32'h0000_1003, 32'h0, 5'd7, 32'h80FF_1234, 0, 0);
    check("lb_value", bus.mem_data, 32'hFFFF_FF80);
    check("lb_rd", 32'(bus.wb_rd), 32'd7);
    run_op(1'b0, 3'd5, 32'h0000_2002, 32'h0, 5'd3, 32'hBEEF_0001, 0, 0);
    check("lhu_value", bus.mem_data, 32'h0000_BEEF);
    run_op(1'b0, 3'd1, 32'h0000_2002, 32'h0, 5'd4, 32'hBEEF_0001, 1, 2);
    check("lh_value", bus.mem_data, 32'hFFFF_BEEF);
    run_op(1'b0, 3'd2, 32'h0000_2000, 32'h0, 5'd5, 32'hBEEF_0001, 0, 0);
    check("lw_value", bus.mem_data, 32'hBEEF_0001);
    run_op(1'b1, 3'd0, 32'h0000_3001, 32'h0000_00A5, 5'd0, 32'h0, 4, 0);
    run_op(1'b1, 3'd2, 32'h0000_4002, 32'h1234_5678, 5'd0, 32'h0, 0, 0);
    check("sw_mis_cause", 32'(bus.fault_cause), 32'd0);
    run_op(1'b0, 3'd3, 32'h0000_4000, 32'h0, 5'd1, 32'h0, 0, 0);
    check("ld_ill_cause", 32'(bus.fault_cause), 32'd1);
    run_op(1'b1, 3'd1, 32'h0000_5001, 32'hCAFE_F00D, 5'd0, 32'h0, 0, 0);
    run_op(1'b0, 3'd2, 32'h0000_6000, 32'h0, 5'd9, 32'h0, 0, -1);
    run_op(1'b0, 3'd2, 32'h0000_6004, 32'h0, 5'd10, 32'h1357_9BDF, 0, 0);
    // Response in the same cycle the timeout would fire
    run_op(1'b0, 3'd4, 32'h0000_6006, 32'h0, 5'd11, 32'h00C3_0000, 0, 7);
    check("edge_rsp_wins", bus.mem_data, 32'h0000_00C3);

    // Reset in the middle of a load's WAIT phase
    run_op(1'b0, 3'd2, 32'h0000_7000, 32'h0, 5'd12, 32'h0, 0, -1);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.is_store  = 1'b0;
    bus.funct3    = 3'd2;
    bus.addr      = 32'h0000_7008;
    bus.rd_addr   = 5'd13;
    @(posedge clk);
    #1;
    bus.req_valid     = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_req_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = 32'hDEAD_BEEF;
    exp_cause         = 2'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("late_rsp_no_wb", 32'(bus.wb_valid), 32'd0);
    end
    bus.mem_rsp_valid = 1'b0;
    run_op(1'b0, 3'd2, 32'h0000_8000, 32'h0, 5'd14, 32'h2468_ACE0, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      st = 1'($urandom);
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom);
      else if (st) f3 = 3'($urandom_range(0, 2));
      else begin
        f3 = 3'($urandom_range(0, 4));
        if (f3 == 3'd3) f3 = 3'd5;
      end
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      case ($urandom_range(0, 19))
        0:       pd = -1;
        1:       pd = 7;
        default: pd = $urandom_range(0, 3);
      endcase
      run_op(st, f3, a, $urandom, 5'($urandom), $urandom, $urandom_range(0, 3), pd);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
